// File: rtl/wb_fill_master.sv
// Wishbone classic master that writes a rectangular fill of 32-bit words.
// Optional macro WB_FILL_PATTERN_EN: write data becomes fill_data + column (per-row ramp).
module wb_fill_master #(
  parameter int DIM_W          = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      stride,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_addr_o,
  output logic [31:0]      wb_data_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_NEXT, S_DONE} state_t;

  localparam int              TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0]   TO_LOAD = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
  logic [31:0]        row_base_q, row_base_d, stride_q, stride_d, fill_q, fill_d;
  logic [TW-1:0]      wait_q, wait_d;
  logic               error_q, error_d;
  logic               last_col, last_row, timeout;

  assign last_col = (col_q == width_q - ONE);
  assign last_row = (row_q == height_q - ONE);
  // Wait timer is a down-counter reloaded on every entry to REQ.
  assign timeout  = TO_EN && (wait_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      width_q    <= '0;
      height_q   <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      fill_q     <= '0;
      wait_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      width_q    <= width_d;
      height_q   <= height_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      fill_q     <= fill_d;
      wait_q     <= wait_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    width_d    = width_q;
    height_d   = height_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    fill_d     = fill_q;
    wait_d     = wait_q;
    error_d    = error_q;
    unique case (state_q)
      S_IDLE: begin
        wait_d = TO_LOAD;
        if (start) begin
          width_d    = width;
          height_d   = height;
          stride_d   = stride;
          fill_d     = fill_data;
          row_base_d = base_addr;
          col_d      = '0;
          row_d      = '0;
          error_d    = 1'b0;
          state_d    = (width == '0 || height == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (wait_q != '0) wait_d = wait_q - TW'(1);
        // Error beats ack; ack in the timeout cycle still completes the word.
        if (wb_err_i) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (wb_ack_i) begin
          if (last_col && last_row) begin
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
            if (last_col) begin
              col_d      = '0;
              row_d      = row_q + ONE;
              row_base_d = row_base_q + stride_q;
            end else begin
              col_d = col_q + ONE;
            end
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_NEXT: begin
        wait_d  = TO_LOAD;
        state_d = S_REQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wb_stb_o  = (state_q == S_REQ);
    wb_cyc_o  = wb_stb_o;
    wb_we_o   = wb_stb_o;
    wb_sel_o  = wb_stb_o ? 4'hF : 4'h0;
    wb_addr_o = wb_stb_o ? (row_base_q + (32'(col_q) << 2)) : 32'h0;
`ifdef WB_FILL_PATTERN_EN
    wb_data_o = wb_stb_o ? (fill_q + 32'(col_q)) : 32'h0;
`else
    wb_data_o = wb_stb_o ? fill_q : 32'h0;
`endif
    busy      = (state_q == S_REQ) || (state_q == S_NEXT);
    done      = (state_q == S_DONE);
    error     = error_q;
  end

endmodule

// File: tb/tb_wb_fill_master.sv
// Self-checking bench for wb_fill_master: directed and random fills against a
// Wishbone slave model and an arithmetic reference of the expected write list.
module tb_wb_fill_master;

  localparam int DIM_W   = 10;
  localparam int TIMEOUT = 255;
  localparam int LIMIT   = 6000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr, stride, fill_data;
  logic [DIM_W-1:0] width, height;
  logic             busy, done, error;
  logic             wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]       wb_sel_o;
  logic [31:0]      wb_addr_o, wb_data_o;
  logic             wb_ack_i, wb_err_i;

  int checks = 0;
  int errors = 0;

  // slave model configuration and log
  int          wait_word, wait_n, err_word, never_ack, stray;
  int          word_idx, wcnt, stb_cyc, unstable, bad_ctl;
  logic [31:0] hold_addr, hold_data;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  wb_fill_master #(.DIM_W(DIM_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .width(width), .height(height), .fill_data(fill_data), .busy(busy), .done(done),
    .error(error), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: decides ack/err at the falling edge for the coming rising edge.
  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (reset) begin
        wcnt = 0;
      end else if (wb_stb_o) begin
        if (wcnt == 0) begin
          hold_addr = wb_addr_o;
          hold_data = wb_data_o;
        end else if (wb_addr_o !== hold_addr || wb_data_o !== hold_data) begin
          unstable++;
        end
        if (wb_we_o !== 1'b1 || wb_sel_o !== 4'hF || wb_cyc_o !== 1'b1) bad_ctl++;
        stb_cyc++;
        if (never_ack != 0) begin
          wcnt++;
        end else if (word_idx == err_word) begin
          wb_err_i = 1'b1;
          wcnt = 0;
          word_idx++;
        end else if (word_idx == wait_word && wcnt < wait_n) begin
          wcnt++;
        end else begin
          wb_ack_i = 1'b1;
          q_addr.push_back(wb_addr_o);
          q_data.push_back(wb_data_o);
          wcnt = 0;
          word_idx++;
        end
      end else begin
        wcnt = 0;
        if (stray != 0) wb_ack_i = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] s,
                     input int w, input int h, input logic [31:0] f,
                     input int ww, input int wn, input int ew, input int na);
    int total, issued, stbcyc, acc, expk, k, donek, ndone, firststb, postcyc, cycseen;
    int r, c;
    bit abort;
    logic [31:0] ea, ed;
    total = w * h;
    abort = (total != 0) && ((na != 0) || (ew >= 0 && ew < total));
    if (total == 0) begin
      issued = 0; stbcyc = 0; acc = 0; expk = 1;
    end else if (na != 0) begin
      issued = 1; stbcyc = TIMEOUT; acc = 0; expk = 1 + TIMEOUT;
    end else begin
      issued = abort ? ew + 1 : total;
      acc    = abort ? ew : total;
      stbcyc = issued + ((ww < issued && ww != ew) ? wn : 0);
      expk   = 1 + stbcyc + issued - 1;
    end
    wait_word = ww; wait_n = wn; err_word = ew; never_ack = na;
    word_idx = 0; stb_cyc = 0; unstable = 0; bad_ctl = 0;
    q_addr.delete();
    q_data.delete();

    @(posedge clk); #1;
    start = 1'b1; base_addr = b; stride = s; fill_data = f;
    width = DIM_W'(w); height = DIM_W'(h);
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = $urandom; stride = $urandom; fill_data = $urandom;
    width = DIM_W'($urandom); height = DIM_W'($urandom);
    chk($sformatf("%s.err_clr", tag), error, 0);
    chk($sformatf("%s.busy", tag), busy, (total != 0));

    k = 1; donek = 0; ndone = 0; firststb = 0; postcyc = 0; cycseen = 0;
    while (k < LIMIT) begin
      if (wb_stb_o && firststb == 0) firststb = k;
      if (wb_cyc_o) cycseen = 1;
      if (donek != 0 && k > donek && wb_cyc_o) postcyc++;
      if (done) begin
        ndone++;
        if (donek == 0) begin
          donek = k;
          chk($sformatf("%s.busy_done", tag), busy, 0);
        end
      end
      if (donek != 0 && k == donek) start = 1'b1;
      if (donek != 0 && k == donek + 1) start = 1'b0;
      if (donek != 0 && k >= donek + 4) break;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;

    chk($sformatf("%s.ndone", tag), ndone, 1);
    chk($sformatf("%s.done_cycle", tag), donek, expk);
    chk($sformatf("%s.first_stb", tag), firststb, (total != 0) ? 1 : 0);
    chk($sformatf("%s.cyc_seen", tag), cycseen, (total != 0) ? 1 : 0);
    chk($sformatf("%s.no_restart", tag), postcyc, 0);
    chk($sformatf("%s.stb_cycles", tag), stb_cyc, stbcyc);
    chk($sformatf("%s.words", tag), q_addr.size(), acc);
    chk($sformatf("%s.stable", tag), unstable, 0);
    chk($sformatf("%s.ctl", tag), bad_ctl, 0);
    chk($sformatf("%s.error", tag), error, abort);
    for (int i = 0; i < acc && i < q_addr.size(); i++) begin
      r  = i / w;
      c  = i % w;
      ea = b + 32'(r) * s + 32'(4 * c);
`ifdef WB_FILL_PATTERN_EN
      ed = f + 32'(c);
`else
      ed = f;
`endif
      chk($sformatf("%s.addr%0d", tag, i), q_addr[i], ea);
      chk($sformatf("%s.data%0d", tag, i), q_data[i], ed);
    end
  endtask

  initial begin
    int cnt, w, h, ww, wn, ew;
    reset = 1'b1; start = 1'b1;
    base_addr = 32'h1234_5678; stride = 32'h40; fill_data = 32'hDEAD_BEEF;
    width = 10'd3; height = 10'd3;
    wait_word = -1; wait_n = 0; err_word = -1; never_ack = 0; stray = 0;
    word_idx = 0; stb_cyc = 0; unstable = 0; bad_ctl = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, error, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
                          wb_addr_o, wb_data_o}, 0);
    start = 1'b0;
    reset = 1'b0;

    stray = 1;
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (wb_cyc_o || busy || done) cnt++;
    end
    chk("idle_quiet", cnt, 0);
    chk("idle_outputs", {error, wb_stb_o, wb_sel_o, wb_addr_o, wb_data_o}, 0);
    stray = 0;

    run("basic3x2", 32'h3000_0000, 32'h40, 3, 2, 32'hA5A5_A5A5, -1, 0, -1, 0);
    run("zero_w", 32'h3000_0000, 32'h40, 0, 5, 32'h1, -1, 0, -1, 0);
    run("zero_h", 32'h3000_1000, 32'h40, 5, 0, 32'h2, -1, 0, -1, 0);
    run("wait3", 32'h3000_0000, 32'h40, 3, 2, 32'h5A5A_0001, 2, 3, -1, 0);
    run("timeout", 32'h3000_0200, 32'h40, 2, 2, 32'h77, -1, 0, -1, 1);
    run("after_to", 32'h3000_0300, 32'h10, 2, 1, 32'h88, -1, 0, -1, 0);
    run("err_w0", 32'h3000_0400, 32'h40, 4, 1, 32'h99, -1, 0, 0, 0);
    run("pattern", 32'h3000_0000, 32'h40, 4, 1, 32'h10, -1, 0, -1, 0);
    run("wrap_max", 32'hFFFF_FF00, 32'hFFFF_F000, 1023, 2, 32'hFFFF_FFFE, 1022, 1, -1, 0);

    stray = 1;
    for (int i = 0; i < 10; i++) begin
      w  = $urandom_range(1, 4);
      h  = $urandom_range(1, 3);
      ww = $urandom_range(0, w * h - 1);
      wn = $urandom_range(0, 4);
      ew = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w * h - 1) : -1;
      run($sformatf("rnd%0d", i), $urandom, $urandom, w, h, $urandom, ww, wn, ew, 0);
    end
    stray = 0;

    // reset in the middle of a transfer
    wait_word = -1; wait_n = 0; err_word = -1; never_ack = 0; word_idx = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h3000_0000; stride = 32'h40; fill_data = 32'h1;
    width = 10'd4; height = 10'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_reset", {busy, done, error, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
                        wb_addr_o, wb_data_o}, 0);
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || wb_cyc_o) cnt++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || wb_cyc_o) cnt++;
    end
    chk("reset_no_done", cnt, 0);

    run("post_reset", 32'h3000_0800, 32'h20, 2, 2, 32'hCAFE_0000, 1, 2, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
